// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O responder: I/O window match
// value, register byte offsets, STATUS bit positions and seven-segment codes.
package io_pkg;

  // addr[31:7] value selecting the 0x80-0xFF I/O window
  localparam logic [24:0] IO_BASE = 25'h1;

  // Register byte offsets
  localparam logic [7:0] OFF_SW0    = 8'h80;
  localparam logic [7:0] OFF_SW1    = 8'h84;
  localparam logic [7:0] OFF_DISP0  = 8'h88;
  localparam logic [7:0] OFF_DISP1  = 8'h8C;
  localparam logic [7:0] OFF_DISP2  = 8'h90;
  localparam logic [7:0] OFF_LED    = 8'h94;
  localparam logic [7:0] OFF_PERIOD = 8'h98;
  localparam logic [7:0] OFF_STATUS = 8'h9C;
  localparam logic [7:0] OFF_COUNT  = 8'hA0;

  // Word index (addr[6:2]) for each offset
  localparam logic [4:0] IDX_SW0    = OFF_SW0[6:2];
  localparam logic [4:0] IDX_SW1    = OFF_SW1[6:2];
  localparam logic [4:0] IDX_DISP0  = OFF_DISP0[6:2];
  localparam logic [4:0] IDX_DISP1  = OFF_DISP1[6:2];
  localparam logic [4:0] IDX_DISP2  = OFF_DISP2[6:2];
  localparam logic [4:0] IDX_LED    = OFF_LED[6:2];
  localparam logic [4:0] IDX_PERIOD = OFF_PERIOD[6:2];
  localparam logic [4:0] IDX_STATUS = OFF_STATUS[6:2];
  localparam logic [4:0] IDX_COUNT  = OFF_COUNT[6:2];

  // STATUS bits
  localparam int ST_TMR = 0;  // timer flag, W1C
  localparam int ST_SW  = 1;  // switch-change flag, W1C
  localparam int ST_IE  = 2;  // timer irq enable, RW

  // Active-low segments, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = SEG_0;
      4'd1:    seg_digit = SEG_1;
      4'd2:    seg_digit = SEG_2;
      4'd3:    seg_digit = SEG_3;
      4'd4:    seg_digit = SEG_4;
      4'd5:    seg_digit = SEG_5;
      4'd6:    seg_digit = SEG_6;
      4'd7:    seg_digit = SEG_7;
      4'd8:    seg_digit = SEG_8;
      4'd9:    seg_digit = SEG_9;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decimal.sv
// Two-digit decimal seven-segment decoder.
//   val_i  : 7-bit value 0-127
//   high_o : tens digit, active-low gfedcba
//   low_o  : units digit, active-low gfedcba
// Values above 99 cannot be shown in two digits and display a dash on both.
module seg7_decimal
  import io_pkg::*;
(
  input  logic [6:0] val_i,
  output logic [6:0] high_o,
  output logic [6:0] low_o
);

  logic [3:0] tens;
  logic [3:0] units;

  always_comb begin
    tens  = 4'(val_i / 7'd10);
    units = 4'(val_i % 7'd10);
    if (val_i > 7'd99) begin
      high_o = SEG_DASH;
      low_o  = SEG_DASH;
    end else begin
      high_o = seg_digit(tens);
      low_o  = seg_digit(units);
    end
  end

endmodule

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder on the CPU memory stage.
//   clock, resetn      : pipeline clock, async active-low reset
//   we, addr, wdata    : store strobe, byte address, store data
//   rdata              : registered load data (one cycle after addr)
//   plus1, plus2       : asynchronous 5-bit switch banks
//   plus1_*/plus2_*/total_* : active-low seven-segment digits for DISP0-2
//   lcd                : LED register
//   irq                : timer flag AND irq enable
// TIMER_W must not exceed 32 (period is loaded from wdata).
module io_port_responder
  import io_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [4:0]  plus1,
  input  logic [4:0]  plus2,
  output logic [6:0]  plus1_high,
  output logic [6:0]  plus1_low,
  output logic [6:0]  plus2_high,
  output logic [6:0]  plus2_low,
  output logic [6:0]  total_high,
  output logic [6:0]  total_low,
  output logic [9:0]  lcd,
  output logic        irq
);

  localparam logic [TIMER_W-1:0] CNT_ONE = TIMER_W'(1);

  // Switch synchronizers plus previous-cycle copy for change detection
  logic [4:0] sw0_s1_q, sw0_q, sw0_prev_q;
  logic [4:0] sw1_s1_q, sw1_q, sw1_prev_q;

  logic [6:0]         disp0_q, disp1_q, disp2_q;
  logic [9:0]         led_q;
  logic [TIMER_W-1:0] period_q, period_d;
  logic [TIMER_W-1:0] count_q, count_d;
  logic [2:0]         status_q, status_d;
  logic [31:0]        rdata_q, rdata_d;

  logic       io_hit;
  logic [4:0] idx;
  logic       wr_disp0, wr_disp1, wr_disp2, wr_led, wr_period, wr_status;
  logic       tmr_tick;
  logic       sw_change;
  logic       unused_bits;

  assign unused_bits = ^addr[1:0];

  // Address decode
  assign io_hit    = (addr[31:7] == IO_BASE);
  assign idx       = addr[6:2];
  assign wr_disp0  = we && io_hit && (idx == IDX_DISP0);
  assign wr_disp1  = we && io_hit && (idx == IDX_DISP1);
  assign wr_disp2  = we && io_hit && (idx == IDX_DISP2);
  assign wr_led    = we && io_hit && (idx == IDX_LED);
  assign wr_period = we && io_hit && (idx == IDX_PERIOD);
  assign wr_status = we && io_hit && (idx == IDX_STATUS);

  assign sw_change = (sw0_q != sw0_prev_q) || (sw1_q != sw1_prev_q);

  // Timer: a PERIOD write restarts the count; PERIOD==0 parks it.
  always_comb begin
    period_d = period_q;
    count_d  = count_q;
    tmr_tick = 1'b0;
    if (wr_period) begin
      period_d = wdata[TIMER_W-1:0];
      count_d  = wdata[TIMER_W-1:0];
    end else if (period_q != '0) begin
      if (count_q == CNT_ONE) begin
        count_d  = period_q;
        tmr_tick = 1'b1;
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  // Set events are OR'd after the W1C so a same-cycle set wins.
  always_comb begin
    status_d         = status_q;
    status_d[ST_TMR] = tmr_tick  | (status_q[ST_TMR] & ~(wr_status & wdata[ST_TMR]));
    status_d[ST_SW]  = sw_change | (status_q[ST_SW]  & ~(wr_status & wdata[ST_SW]));
    if (wr_status) status_d[ST_IE] = wdata[ST_IE];
  end

  // Read mux sees register state before this cycle's write.
  always_comb begin
    rdata_d = '0;
    if (io_hit) begin
      case (idx)
        IDX_SW0:    rdata_d = {27'd0, sw0_q};
        IDX_SW1:    rdata_d = {27'd0, sw1_q};
        IDX_DISP0:  rdata_d = {25'd0, disp0_q};
        IDX_DISP1:  rdata_d = {25'd0, disp1_q};
        IDX_DISP2:  rdata_d = {25'd0, disp2_q};
        IDX_LED:    rdata_d = {22'd0, led_q};
        IDX_PERIOD: rdata_d = 32'(period_q);
        IDX_STATUS: rdata_d = {29'd0, status_q};
        IDX_COUNT:  rdata_d = 32'(count_q);
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw0_s1_q   <= '0;
      sw0_q      <= '0;
      sw0_prev_q <= '0;
      sw1_s1_q   <= '0;
      sw1_q      <= '0;
      sw1_prev_q <= '0;
      disp0_q    <= '0;
      disp1_q    <= '0;
      disp2_q    <= '0;
      led_q      <= '0;
      period_q   <= '0;
      count_q    <= '0;
      status_q   <= '0;
      rdata_q    <= '0;
    end else begin
      sw0_s1_q   <= plus1;
      sw0_q      <= sw0_s1_q;
      sw0_prev_q <= sw0_q;
      sw1_s1_q   <= plus2;
      sw1_q      <= sw1_s1_q;
      sw1_prev_q <= sw1_q;
      if (wr_disp0) disp0_q <= wdata[6:0];
      if (wr_disp1) disp1_q <= wdata[6:0];
      if (wr_disp2) disp2_q <= wdata[6:0];
      if (wr_led)   led_q   <= wdata[9:0];
      period_q   <= period_d;
      count_q    <= count_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign lcd   = led_q;
  assign irq   = status_q[ST_TMR] & status_q[ST_IE];

  seg7_decimal u_seg_p1 (.val_i(disp0_q), .high_o(plus1_high), .low_o(plus1_low));
  seg7_decimal u_seg_p2 (.val_i(disp1_q), .high_o(plus2_high), .low_o(plus2_low));
  seg7_decimal u_seg_tt (.val_i(disp2_q), .high_o(total_high), .low_o(total_low));

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder with hand-computed expectations.
module tb_io_port_responder;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [4:0]  plus1 = '0;
  logic [4:0]  plus2 = '0;
  logic [6:0]  p1h, p1l, p2h, p2l, tth, ttl;
  logic [9:0]  lcd;
  logic        irq;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;

  io_port_responder #(.TIMER_W(32)) dut (
    .clock(clock), .resetn(resetn), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .plus1(plus1), .plus2(plus2),
    .plus1_high(p1h), .plus1_low(p1l), .plus2_high(p2h), .plus2_low(p2l),
    .total_high(tth), .total_low(ttl), .lcd(lcd), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; we = 1'b0;
    step();
    d = rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;

    // Reset state
    #12;
    chk("reset_rdata", rdata, 0);
    chk("reset_lcd", lcd, 0);
    chk("reset_irq", irq, 0);
    chk("reset_digits", {p1h, p1l, p2h, p2l, tth, ttl}, {S0, S0, S0, S0, S0, S0});
    @(negedge clock);
    resetn = 1'b1;

    // Display decode
    wr(32'h88, 37);
    wr(32'h8C, 5);
    wr(32'h90, 100);
    chk("disp0_37", {p1h, p1l}, {S3, S7});
    chk("disp1_5", {p2h, p2l}, {S0, S5});
    chk("disp2_100", {tth, ttl}, {SD, SD});
    wr(32'h88, 32'hFF);
    chk("disp0_127_dash", {p1h, p1l}, {SD, SD});
    rd(32'h88, r);
    chk("disp0_rd_7bit", r, 32'h7F);
    wr(32'h88, 99);
    chk("rd_during_wr_old", rdata, 32'h7F);
    chk("disp0_99", {p1h, p1l}, {S9, S9});
    rd(32'h90, r);
    chk("disp2_rd", r, 100);

    // Switch sync and change flag
    plus1 = 5'h15;
    step(); step(); step();
    rd(32'h80, r);
    chk("sw0_rd", r, 32'h15);
    rd(32'h84, r);
    chk("sw1_rd", r, 0);
    rd(32'h9C, r);
    chk("status_sw_flag", r, 2);
    wr(32'h9C, 2);
    rd(32'h9C, r);
    chk("status_sw_cleared", r, 0);
    rd(32'hA4, r);
    chk("unmapped_rd", r, 0);

    // Timer sequence 3,2,1,3 with irq every third cycle
    wr(32'h9C, 4);
    wr(32'h98, 3);
    rd(32'hA0, r);
    chk("count_3", r, 3);
    chk("irq_c1", irq, 0);
    rd(32'hA0, r);
    chk("count_2", r, 2);
    chk("irq_c2", irq, 0);
    rd(32'hA0, r);
    chk("count_1", r, 1);
    chk("irq_c3", irq, 1);
    rd(32'hA0, r);
    chk("count_reload", r, 3);
    wr(32'h9C, 5);
    chk("irq_w1c", irq, 0);
    step();
    chk("irq_next_period", irq, 1);

    // Clear racing a reload: reload wins
    wr(32'h9C, 5);
    chk("irq_w1c_2", irq, 0);
    step();
    chk("irq_mid", irq, 0);
    wr(32'h9C, 5);
    chk("irq_set_wins", irq, 1);
    rd(32'h9C, r);
    chk("status_set_wins", r, 5);

    // Non-I/O alias and RO write
    wr(32'h10000094, 32'h3FF);
    chk("lcd_alias_ignored", lcd, 0);
    rd(32'h10000094, r);
    chk("alias_rd_zero", r, 0);
    wr(32'h00000094, 32'h3FF);
    chk("lcd_set", lcd, 10'h3FF);
    rd(32'h94, r);
    chk("lcd_rd", r, 32'h3FF);
    wr(32'h80, 32'h1F);
    rd(32'h80, r);
    chk("sw0_ro", r, 32'h15);

    // Short asynchronous reset while counting
    addr = 32'hA0;
    step();
    #1;
    resetn = 1'b0;
    #1;
    chk("areset_rdata", rdata, 0);
    chk("areset_lcd", lcd, 0);
    chk("areset_irq", irq, 0);
    chk("areset_digits", {p1h, p1l, p2h, p2l, tth, ttl}, {S0, S0, S0, S0, S0, S0});
    #2;
    resetn = 1'b1;
    rd(32'hA0, r);
    chk("count_idle_1", r, 0);
    rd(32'hA0, r);
    chk("count_idle_2", r, 0);
    rd(32'hA0, r);
    chk("count_idle_3", r, 0);
    rd(32'h98, r);
    chk("period_idle", r, 0);
    rd(32'h9C, r);
    chk("tmr_flag_idle", r[0], 0);
    chk("irq_idle", irq, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
